ladder_operand_loader: RTL and testbench
========================================

# ladder_operand_loader

Front-end stage for the Montgomery-ladder exponentiator. It accepts the five 1024-bit operands (x, m, e, r, r2) as a 32-bit word stream and assembles them into operand registers. It then left-aligns the exponent so its most significant set bit lands in bit 1023 and computes its bit length. Finally it issues a one-cycle start to the ladder and holds every operand stable until the ladder reports done.

## Interface
Parameters:
- WORDS, 32, 32-bit words per 1024-bit operand
- NOPS, 5, operands per load, in order x, m, e, r, r2

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-high reset; asserted high it clears all state immediately
- start  in  1  begin a load; sampled only in IDLE
- in_valid  in  1  stream word valid
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  32  stream word; each operand is sent least-significant word first
- out_x, out_m, out_r, out_r2  out  1024  assembled operands
- out_e  out  1024  exponent, left-aligned
- out_lene  out  32  bit length of e (1..1024)
- ladder_start  out  1  one-cycle pulse to the ladder
- ladder_done  in  1  ladder completion pulse
- busy  out  1  high whenever state is not IDLE
- err_zero_e  out  1  one-cycle pulse when a loaded e is zero

## Operation
- States: IDLE, LOAD, NORM_W, NORM_B, ISSUE, WAIT.
- IDLE:
  - start=1 moves to LOAD.
  - The word counter (8 bits), the shift counter (11 bits) and all operand registers are cleared on that transition.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid && in_ready writes in_data into the operand selected by cnt[7:5], at bits [cnt[4:0]*32 +: 32], then increments cnt.
  - When the transfer at cnt=159 completes, go to NORM_W.
- NORM_W:
  - If e[1023:992]==0 and e!=0, shift e left by 32 and add 32 to the shift counter. Otherwise go to NORM_B.
  - If e==0 on entry, pulse err_zero_e and go to IDLE; ladder_start is never issued.
- NORM_B:
  - If e[1023]==0, shift e left by 1 and add 1 to the shift counter. Otherwise latch out_lene = 1024 - shift and go to ISSUE.
- ISSUE: ladder_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - All outputs are held.
  - ladder_done=1 returns to IDLE. out_* keep their values until the next start.
- start outside IDLE is ignored.
- ladder_done outside WAIT is ignored.

## Timing
- Reset values: all out_* zero, out_lene=0, in_ready=0, ladder_start=0, busy=0, err_zero_e=0, state IDLE.
- Reset mid-operation aborts immediately. Partial operands are discarded and zeroed, and no ladder_start is produced.
- in_ready is combinational from state only, never from in_valid.
- Stream stalls (in_valid=0) insert idle cycles without penalty.
- Normalization latency:
  - NORM_W: at most 31 shift cycles plus 1 exit cycle.
  - NORM_B: at most 31 shift cycles plus 1 exit cycle.
  - Worst case (e=1) is 31+1+31+1 = 64 cycles from the last LOAD word to ISSUE.
  - Best case (e[1023]=1) is 2 cycles to ISSUE.
- ladder_start is asserted the cycle after NORM_B exits. out_e and out_lene are already valid in that cycle.
- busy stays high from the cycle after start is accepted until the cycle after ladder_done.

## Structure
- Shared package holds:
  - state encoding constants (3 bits)
  - operand index constants: X=0, M=1, E=2, R=3, R2=4
  - WORDS and the derived total of 160 words
- Natural sub-module: exp_normalizer, holding the e register, the word and bit shift logic, the shift counter and the out_lene computation, controlled by load/shift_w/shift_b enables from the top FSM.
- The top level keeps the FSM, the word counter and the four plain operand registers.

## Test plan
- Full load with x=0x1234..., e=0x1 (word 0 = 1, others 0) -> out_e[1023]=1 with all other bits 0, out_lene=1, ladder_start pulses exactly 64 cycles after the last word.
- e with bit 1023 set (word 31 = 0x8000_0000) -> out_lene=1024, out_e unchanged, ISSUE 2 cycles after the last word.
- e = 0x10001 (65537) -> out_lene=17, out_e[1023:1007]=17'h10001; all other operands are bit-exact copies of the stream.
- e all zero -> err_zero_e pulses once, no ladder_start, returns to IDLE with busy=0.
- Random in_valid gaps (about 50%) plus start pulses during LOAD/WAIT -> identical operand registers to the gapless run, extra starts ignored, ladder_done in IDLE ignored.
- resetn asserted at word 80 -> all outputs zero immediately; a fresh load afterwards completes correctly.

Source files
------------

// File: rtl/ladder_operand_loader_pkg.sv
// Shared constants for the ladder operand loader: FSM encoding, operand
// indices and stream geometry.
package ladder_operand_loader_pkg;

    localparam int WORDS_PER_OP = 32;
    localparam int TOTAL_WORDS  = WORDS_PER_OP * 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_NORM_W = 3'd2,
        ST_NORM_B = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_WAIT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_X  = 3'd0;
    localparam logic [2:0] OP_M  = 3'd1;
    localparam logic [2:0] OP_E  = 3'd2;
    localparam logic [2:0] OP_R  = 3'd3;
    localparam logic [2:0] OP_R2 = 3'd4;

endpackage

// File: rtl/ladder_operand_loader_exp_normalizer.sv
// Exponent register with word/bit left-alignment, shift counter and bit-length
// latch; all steps are enabled by the loader FSM.
module ladder_operand_loader_exp_normalizer (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [4:0]    i_word_idx,
    input  logic [31:0]   i_data,
    input  logic          i_shift_w,
    input  logic          i_shift_b,
    input  logic          i_latch,
    output logic [1023:0] o_e,
    output logic          o_e_zero,
    output logic          o_top_zero,
    output logic          o_msb,
    output logic [31:0]   o_lene
);

    logic [1023:0] r_e;
    logic [10:0]   r_shift;
    logic [31:0]   r_lene;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_e     <= '0;
            r_shift <= '0;
            r_lene  <= '0;
        end else if (i_clr) begin
            r_e     <= '0;
            r_shift <= '0;
            r_lene  <= '0;
        end else begin
            if (i_load) begin
                r_e[{i_word_idx, 5'd0} +: 32] <= i_data;
            end else if (i_shift_w) begin
                r_e     <= r_e << 32;
                r_shift <= r_shift + 11'd32;
            end else if (i_shift_b) begin
                r_e     <= r_e << 1;
                r_shift <= r_shift + 11'd1;
            end
            // The shift count never exceeds 1023, so the length stays in 1..1024.
            if (i_latch) begin
                r_lene <= 32'd1024 - {21'd0, r_shift};
            end
        end
    end

    assign o_e        = r_e;
    assign o_e_zero   = (r_e == '0);
    assign o_top_zero = (r_e[1023:992] == 32'd0);
    assign o_msb      = r_e[1023];
    assign o_lene     = r_lene;

endmodule

// File: rtl/ladder_operand_loader.sv
// Streams five 1024-bit operands in, left-aligns the exponent, pulses the
// ladder start and holds every operand until the ladder reports done.
module ladder_operand_loader
    import ladder_operand_loader_pkg::*;
#(
    parameter int WORDS = 32,
    parameter int NOPS  = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic [1023:0] out_x,
    output logic [1023:0] out_m,
    output logic [1023:0] out_e,
    output logic [1023:0] out_r,
    output logic [1023:0] out_r2,
    output logic [31:0]   out_lene,
    output logic          ladder_start,
    input  logic          ladder_done,
    output logic          busy,
    output logic          err_zero_e,
    output logic [2:0]    o_dbg_state
);

    localparam logic [7:0] LAST_CNT = 8'(WORDS * NOPS - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_cnt;
    logic [1023:0] r_x, r_m, r_r, r_r2;

    logic       w_start_load;
    logic       w_accept;
    logic [2:0] w_op_sel;
    logic [4:0] w_word;
    logic       w_e_load;
    logic       w_shift_w;
    logic       w_shift_b;
    logic       w_latch;
    logic       w_e_zero;
    logic       w_top_zero;
    logic       w_msb;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends on state only, so a source may hold in_valid indefinitely.
    assign w_start_load = (r_state == ST_IDLE) && start;
    assign w_accept     = in_valid && in_ready;
    assign w_op_sel     = r_cnt[7:5];
    assign w_word       = r_cnt[4:0];

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_LOAD;
            ST_LOAD:   if (w_accept && r_cnt == LAST_CNT) w_next_state = ST_NORM_W;
            ST_NORM_W: begin
                if (w_e_zero)        w_next_state = ST_IDLE;
                else if (!w_top_zero) w_next_state = ST_NORM_B;
            end
            ST_NORM_B: if (w_msb) w_next_state = ST_ISSUE;
            ST_ISSUE:  w_next_state = ST_WAIT;
            ST_WAIT:   if (ladder_done) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        ladder_start = 1'b0;
        err_zero_e   = 1'b0;
        w_shift_w    = 1'b0;
        w_shift_b    = 1'b0;
        w_latch      = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD:   in_ready = 1'b1;
            ST_NORM_W: begin
                err_zero_e = w_e_zero;
                w_shift_w  = !w_e_zero && w_top_zero;
            end
            ST_NORM_B: begin
                w_shift_b = !w_msb;
                w_latch   = w_msb;
            end
            ST_ISSUE:  ladder_start = 1'b1;
            default:   ;
        endcase
    end

    assign w_e_load = w_accept && (w_op_sel == OP_E);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_m   <= '0;
            r_r   <= '0;
            r_r2  <= '0;
        end else if (w_start_load) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_m   <= '0;
            r_r   <= '0;
            r_r2  <= '0;
        end else if (w_accept) begin
            case (w_op_sel)
                OP_X:    r_x[{w_word, 5'd0} +: 32]  <= in_data;
                OP_M:    r_m[{w_word, 5'd0} +: 32]  <= in_data;
                OP_R:    r_r[{w_word, 5'd0} +: 32]  <= in_data;
                OP_R2:   r_r2[{w_word, 5'd0} +: 32] <= in_data;
                default: ;
            endcase
            r_cnt <= r_cnt + 8'd1;
        end
    end

    ladder_operand_loader_exp_normalizer u_norm (
        .i_clk      (clk),
        .i_rst      (resetn),
        .i_clr      (w_start_load),
        .i_load     (w_e_load),
        .i_word_idx (w_word),
        .i_data     (in_data),
        .i_shift_w  (w_shift_w),
        .i_shift_b  (w_shift_b),
        .i_latch    (w_latch),
        .o_e        (out_e),
        .o_e_zero   (w_e_zero),
        .o_top_zero (w_top_zero),
        .o_msb      (w_msb),
        .o_lene     (out_lene)
    );

    assign out_x       = r_x;
    assign out_m       = r_m;
    assign out_r       = r_r;
    assign out_r2      = r_r2;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ladder_operand_loader.sv
// Directed bench for ladder_operand_loader: table of exponent cases plus
// hand-written sequences for stalls, stray control pulses and mid-load reset.
module tb_ladder_operand_loader;
    import ladder_operand_loader_pkg::*;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic [1023:0] out_x, out_m, out_e, out_r, out_r2;
    logic [31:0]   out_lene;
    logic          ladder_start;
    logic          ladder_done;
    logic          busy;
    logic          err_zero_e;
    logic [2:0]    o_dbg_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1023:0] e;
        logic [31:0]   lene;
        int            lat;
        bit            zero;
        int            gap;
        int            salt;
    } vec_t;

    vec_t vecs[6];

    ladder_operand_loader dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_x        (out_x),
        .out_m        (out_m),
        .out_e        (out_e),
        .out_r        (out_r),
        .out_r2       (out_r2),
        .out_lene     (out_lene),
        .ladder_start (ladder_start),
        .ladder_done  (ladder_done),
        .busy         (busy),
        .err_zero_e   (err_zero_e),
        .o_dbg_state  (o_dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act_top=%h act_low=%h act_ones=%0d exp_top=%h exp_low=%h exp_ones=%0d",
                     name, act[1023:992], act[31:0], $countones(act),
                     exp[1023:992], exp[31:0], $countones(exp));
        end
    endtask

    function automatic logic [31:0] gen_word(input int op, input int w, input int salt);
        case (op)
            0:       return 32'h1234_0000 | 32'(w);
            1:       return 32'hA5A5_0000 ^ 32'(w << 8) ^ 32'(salt);
            3:       return ~(32'(w) * 32'h0101_0101);
            default: return 32'hC0DE_0000 + 32'(w * 7) + 32'(salt << 12);
        endcase
    endfunction

    function automatic logic [31:0] out_word(input int op, input int w);
        case (op)
            0:       return out_x[w*32 +: 32];
            1:       return out_m[w*32 +: 32];
            3:       return out_r[w*32 +: 32];
            default: return out_r2[w*32 +: 32];
        endcase
    endfunction

    // Driver: start pulse then the 160-word stream, optionally with gaps and stray starts.
    task automatic load(input logic [1023:0] e, input int gap, input int salt, input int abort_at);
        logic [31:0] word;
        int op;
        int w;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_in_load", 32'(in_ready), 32'd1);
        for (int k = 0; k < 160; k++) begin
            if (k == abort_at) begin
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            op   = k / 32;
            w    = k % 32;
            word = (op == 2) ? e[w*32 +: 32] : gen_word(op, w, salt);
            while (gap > 0 && $urandom_range(99, 0) < gap) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                start    = 1'($urandom_range(1, 0));
                @(posedge clk);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = word;
            start    = (gap > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            if (op != 2) exp_q.push_back(word);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Scoreboard: the plain operands must equal the stream words in order.
    task automatic check_operands(input string tag);
        logic [31:0] exp;
        int errs;
        errs = 0;
        foreach (vecs[0].e[i]) begin end
        for (int op = 0; op < 5; op++) begin
            if (op == 2) continue;
            for (int w = 0; w < 32; w++) begin
                if (exp_q.size() == 0) begin
                    errs++;
                end else begin
                    exp = exp_q.pop_front();
                    if (out_word(op, w) !== exp) begin
                        errs++;
                        if (errs < 4)
                            $display("FAIL %s_op%0d_w%0d act=%0h exp=%0h", tag, op, w, out_word(op, w), exp);
                    end
                end
            end
        end
        chk({tag, "_operand_errs"}, 32'(errs), 32'd0);
    endtask

    task automatic run_vector(input int i);
        int n;
        int stray;
        logic [31:0] lene_hold;
        load(vecs[i].e, vecs[i].gap, vecs[i].salt, -1);
        n = 0;
        while (!ladder_start && !err_zero_e && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
        if (vecs[i].zero) begin
            chk($sformatf("v%0d_err_pulse", i), 32'(err_zero_e), 32'd1);
            chk($sformatf("v%0d_no_start_at_err", i), 32'(ladder_start), 32'd0);
            chk_w($sformatf("v%0d_out_e_zero", i), out_e, '0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_err_once", i), 32'(err_zero_e), 32'd0);
            chk($sformatf("v%0d_busy_idle", i), 32'(busy), 32'd0);
            stray = 0;
            for (int c = 0; c < 5; c++) begin
                if (ladder_start || err_zero_e) stray++;
                @(posedge clk);
                @(negedge clk);
            end
            chk($sformatf("v%0d_quiet_after_err", i), 32'(stray), 32'd0);
        end else begin
            chk($sformatf("v%0d_ladder_start", i), 32'(ladder_start), 32'd1);
            chk($sformatf("v%0d_err_none", i), 32'(err_zero_e), 32'd0);
            chk_w($sformatf("v%0d_out_e", i), out_e, vecs[i].e << (1024 - int'(vecs[i].lene)));
            chk($sformatf("v%0d_lene", i), out_lene, vecs[i].lene);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_start_one_cycle", i), 32'(ladder_start), 32'd0);
            chk($sformatf("v%0d_state_wait", i), 32'(o_dbg_state), 32'(ST_WAIT));
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk($sformatf("v%0d_start_ignored_wait", i), 32'(o_dbg_state), 32'(ST_WAIT));
            lene_hold = out_lene;
            ladder_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ladder_done = 1'b0;
            chk($sformatf("v%0d_busy_after_done", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_lene_held", i), out_lene, vecs[i].lene);
            ladder_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ladder_done = 1'b0;
            chk($sformatf("v%0d_done_in_idle", i), 32'(o_dbg_state), 32'(ST_IDLE));
            chk($sformatf("v%0d_lene_after_idle_done", i), out_lene, lene_hold);
        end
        check_operands($sformatf("v%0d", i));
    endtask

    initial begin
        resetn      = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        ladder_done = 1'b0;

        vecs[0] = '{e: 1024'd1, lene: 32'd1, lat: 64, zero: 1'b0, gap: 0, salt: 0};
        vecs[1] = '{e: {1'b1, 1023'd0}, lene: 32'd1024, lat: 2, zero: 1'b0, gap: 0, salt: 1};
        vecs[2] = '{e: 1024'h10001, lene: 32'd17, lat: 48, zero: 1'b0, gap: 0, salt: 2};
        vecs[3] = '{e: '0, lene: 32'd650, lat: 35, zero: 1'b0, gap: 0, salt: 3};
        vecs[3].e[20*32 +: 32] = 32'h0000_0300;
        vecs[3].e[3*32 +: 32]  = 32'hDEAD_BEEF;
        vecs[4] = '{e: '0, lene: 32'd0, lat: 0, zero: 1'b1, gap: 0, salt: 4};
        vecs[5] = '{e: 1024'h10001, lene: 32'd17, lat: 48, zero: 1'b0, gap: 50, salt: 2};

        // Reset block
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_w("rst_out_x", out_x, '0);
        chk_w("rst_out_e", out_e, '0);
        chk("rst_lene", out_lene, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ladder_start", 32'(ladder_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_zero_e), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
        resetn = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vector(i);
        end

        // Reset asserted part-way through the stream
        load(vecs[0].e, 0, 7, 80);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk_w("abort_out_x", out_x, '0);
        chk_w("abort_out_m", out_m, '0);
        chk_w("abort_out_e", out_e, '0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_start", 32'(ladder_start), 32'd0);
        resetn = 1'b0;
        exp_q.delete();
        run_vector(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
